// File: rtl/fp_unpk_seq.sv
// Sequential IEEE-754 single/double operand unpacker: extracts sign, exponent, mantissa and class,
// and normalizes subnormals a few bits per cycle so downstream stages always see a hidden bit.
module fp_unpk_seq #(
  parameter int SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] data,
  input  logic [1:0]  fmt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sig,
  output logic [13:0] expo,
  output logic [53:0] mant,
  output logic [9:0]  fclass,
  output logic        snan,
  output logic        qnan,
  output logic        infs,
  output logic        zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, DONE = 2'd2} state_t;

  localparam logic [4:0] STEP5 = 5'(SHIFT_STEP);

  // Singles live at the top of the 53-bit frame, so the visible mantissa is the frame shifted down.
  function automatic logic [53:0] pack_mant(input logic [52:0] m, input logic dbl);
    logic [53:0] res;
    if (dbl) res = {1'b0, m};
    else     res = {30'd0, m[52:29]};
    return res;
  endfunction

  state_t      state_r, state_n;
  logic [52:0] m_r, m_n;
  logic [13:0] e_r, e_n;
  logic        sig_w_r, sig_n;
  logic [9:0]  cls_w_r, cls_n;
  logic        dbl_w_r, dbl_n;
  logic        load_s;

  logic [31:0] sp_s;
  logic        dec_sign_s, dec_max_s, dec_ezero_s, dec_fzero_s, dec_sub_s;
  logic [10:0] dec_exp_s;
  logic [51:0] dec_frac_s;
  logic [9:0]  dec_cls_s;
  logic [52:0] dec_m_s;
  logic [13:0] dec_expo_s;
  logic [4:0]  lz_s;

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);

  // Field extraction and classification of the operand presented at the input.
  always_comb begin
    sp_s = (&data[63:32]) ? data[31:0] : 32'h7FC0_0000;
    if (fmt != 2'd0) begin
      dec_sign_s = data[63];
      dec_exp_s  = data[62:52];
      dec_frac_s = data[51:0];
      dec_max_s  = (data[62:52] == 11'h7FF);
    end else begin
      dec_sign_s = sp_s[31];
      dec_exp_s  = {3'd0, sp_s[30:23]};
      dec_frac_s = {sp_s[22:0], 29'd0};
      dec_max_s  = (sp_s[30:23] == 8'hFF);
    end
    dec_ezero_s = (dec_exp_s == 11'd0);
    dec_fzero_s = (dec_frac_s == 52'd0);
    dec_sub_s   = 1'b0;
    dec_cls_s   = 10'd0;
    if (dec_max_s) begin
      if (dec_fzero_s)         dec_cls_s[dec_sign_s ? 0 : 7] = 1'b1;
      else if (!dec_frac_s[51]) dec_cls_s[8] = 1'b1;
      else                     dec_cls_s[9] = 1'b1;
    end else if (dec_ezero_s) begin
      if (dec_fzero_s) begin
        dec_cls_s[dec_sign_s ? 3 : 4] = 1'b1;
      end else begin
        dec_cls_s[dec_sign_s ? 2 : 5] = 1'b1;
        dec_sub_s = 1'b1;
      end
    end else begin
      dec_cls_s[dec_sign_s ? 1 : 6] = 1'b1;
    end
    // Specials keep the raw exponent but never get a hidden bit.
    dec_m_s    = {!dec_ezero_s && !dec_max_s, dec_frac_s};
    dec_expo_s = dec_sub_s ? 14'd1 : {3'd0, dec_exp_s};
  end

  // Leading-zero count over the top SHIFT_STEP bits of the frame, saturating at SHIFT_STEP.
  always_comb begin
    lz_s = STEP5;
    for (int i = SHIFT_STEP - 1; i >= 0; i--) begin
      if (m_r[52-i]) lz_s = 5'(i);
      else           lz_s = lz_s;
    end
  end

  // Next-state and working-register update.
  always_comb begin
    state_n = state_r;
    m_n     = m_r;
    e_n     = e_r;
    sig_n   = sig_w_r;
    cls_n   = cls_w_r;
    dbl_n   = dbl_w_r;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          m_n   = dec_m_s;
          e_n   = dec_expo_s;
          sig_n = dec_sign_s;
          cls_n = dec_cls_s;
          dbl_n = (fmt != 2'd0);
          if (dec_sub_s) begin
            state_n = NORM;
          end else begin
            state_n = DONE;
            load_s  = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      NORM: begin
        m_n = m_r << lz_s;
        e_n = e_r - {9'd0, lz_s};
        if (lz_s < STEP5) begin
          state_n = DONE;
          load_s  = 1'b1;
        end else begin
          state_n = NORM;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
        else           state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, working registers, and output fields that only load on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      m_r     <= 53'd0;
      e_r     <= 14'd0;
      sig_w_r <= 1'b0;
      cls_w_r <= 10'd0;
      dbl_w_r <= 1'b0;
      sig     <= 1'b0;
      expo    <= 14'd0;
      mant    <= 54'd0;
      fclass  <= 10'd0;
      snan    <= 1'b0;
      qnan    <= 1'b0;
      infs    <= 1'b0;
      zero    <= 1'b0;
    end else begin
      state_r <= state_n;
      m_r     <= m_n;
      e_r     <= e_n;
      sig_w_r <= sig_n;
      cls_w_r <= cls_n;
      dbl_w_r <= dbl_n;
      if (load_s) begin
        sig    <= sig_n;
        expo   <= e_n;
        mant   <= pack_mant(m_n, dbl_n);
        fclass <= cls_n;
        snan   <= cls_n[8];
        qnan   <= cls_n[9];
        infs   <= cls_n[0] | cls_n[7];
        zero   <= cls_n[3] | cls_n[4];
      end
    end
  end

endmodule

// File: tb/tb_fp_unpk_seq.sv
// Directed-vector bench for fp_unpk_seq: hand-computed fields, latency, handshake hold and mid-NORM reset.
module tb_fp_unpk_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] data = 64'd0;
  logic [1:0]  fmt = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sig;
  logic [13:0] expo;
  logic [53:0] mant;
  logic [9:0]  fclass;
  logic        snan, qnan, infs, zero;

  int n_cmp = 0;
  int n_bad = 0;

  fp_unpk_seq #(.SHIFT_STEP(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .fmt(fmt), .out_valid(out_valid), .out_ready(out_ready),
    .sig(sig), .expo(expo), .mant(mant), .fclass(fclass),
    .snan(snan), .qnan(qnan), .infs(infs), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Present one operand, measure latency, check all fields, hold for 'hold' cycles, then release.
  task automatic run_op(input string tag, input logic [63:0] d, input logic [1:0] f,
                        input int exp_lat, input logic exp_sig, input logic [13:0] exp_expo,
                        input logic [53:0] exp_mant, input logic [9:0] exp_cls,
                        input logic [3:0] exp_flags, input int hold);
    int lat;
    @(negedge clk);
    data = d; fmt = f; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val({tag, ".busy"}, {63'd0, in_ready}, 64'd0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check_val({tag, ".sig"}, {63'd0, sig}, {63'd0, exp_sig});
    check_val({tag, ".expo"}, {50'd0, expo}, {50'd0, exp_expo});
    check_val({tag, ".mant"}, {10'd0, mant}, {10'd0, exp_mant});
    check_val({tag, ".class"}, {54'd0, fclass}, {54'd0, exp_cls});
    check_val({tag, ".flags"}, {60'd0, snan, qnan, infs, zero}, {60'd0, exp_flags});
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_val({tag, ".hold_ov"}, {63'd0, out_valid}, 64'd1);
      check_val({tag, ".hold_ir"}, {63'd0, in_ready}, 64'd0);
      check_val({tag, ".hold_expo"}, {50'd0, expo}, {50'd0, exp_expo});
      check_val({tag, ".hold_mant"}, {10'd0, mant}, {10'd0, exp_mant});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val({tag, ".rel_ov"}, {63'd0, out_valid}, 64'd0);
    check_val({tag, ".rel_ir"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int seen;
    #12;
    check_val("rst.ir", {63'd0, in_ready}, 64'd1);
    check_val("rst.ov", {63'd0, out_valid}, 64'd0);
    check_val("rst.fields", {sig, expo, mant, fclass[9:6]}, 64'd0);
    check_val("rst.cls", {54'd0, fclass}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //      tag      data                    fmt  lat sig expo      mant         class       {sn,qn,inf,z} hold
    run_op("s1p0",  64'hFFFFFFFF_3F800000, 2'd0, 1, 1'b0, 14'd127,  54'h800000,  10'h040, 4'b0000, 0);
    run_op("sneg1", 64'hFFFFFFFF_BF800000, 2'd0, 1, 1'b1, 14'd127,  54'h800000,  10'h002, 4'b0000, 0);
    run_op("ssubm", 64'hFFFFFFFF_00000001, 2'd0, 4, 1'b0, 14'h3FEA, 54'h800000,  10'h020, 4'b0000, 0);
    run_op("ssubh", 64'hFFFFFFFF_00400000, 2'd0, 2, 1'b0, 14'd0,    54'h800000,  10'h020, 4'b0000, 0);
    run_op("dsubm", 64'h00000000_00000001, 2'd1, 8, 1'b0, 14'h3FCD, 54'd1 << 52, 10'h020, 4'b0000, 0);
    run_op("snan",  64'hFFFFFFFF_7F800001, 2'd0, 1, 1'b0, 14'hFF,   54'h1,       10'h100, 4'b1000, 0);
    run_op("unbox", 64'h00000000_3F800000, 2'd0, 1, 1'b0, 14'hFF,   54'h400000,  10'h200, 4'b0100, 0);
    run_op("dninf", 64'hFFF00000_00000000, 2'd1, 1, 1'b1, 14'h7FF,  54'd0,       10'h001, 4'b0010, 0);
    run_op("dnzer", 64'h80000000_00000000, 2'd1, 1, 1'b1, 14'd0,    54'd0,       10'h008, 4'b0001, 0);
    run_op("d1fm2", 64'h3FF00000_00000000, 2'd2, 1, 1'b0, 14'd1023, 54'd1 << 52, 10'h040, 4'b0000, 0);
    run_op("hold",  64'hFFFFFFFF_C0400000, 2'd0, 1, 1'b1, 14'd128,  54'hC00000,  10'h002, 4'b0000, 5);

    // Reset while the double minimum subnormal is mid-normalization.
    @(negedge clk);
    data = 64'h1; fmt = 2'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("mrst.ov", {63'd0, out_valid}, 64'd0);
    check_val("mrst.ir", {63'd0, in_ready}, 64'd1);
    check_val("mrst.fields", {sig, expo, mant, fclass[9:6]}, 64'd0);
    check_val("mrst.lo", {54'd0, fclass}, 64'd0);
    check_val("mrst.flags", {60'd0, snan, qnan, infs, zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_val("mrst.noresult", 64'(seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
